audio_clip_scheduler: RTL and testbench
=======================================

AUDIO_CLIP_SCHEDULER -- requirements
Module: audio_clip_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of sound-effect requesters/clips; bit 0 is highest priority.
REQ-002 SHALL have parameter ADDR_W, default 18, sample ROM address width.
REQ-003 SHALL have parameter SAMPLE_DIV, default 1134, Clk cycles per audio sample (50 MHz / ~44.1 kHz).
REQ-004 Clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Req  input  NUM_SRC  per-clip play request; any cycle high latches a pending request.
REQ-007 Mute  input  1  level; aborts playback and discards all pending requests.
REQ-008 Rom_addr  output  ADDR_W  sample ROM read address.
REQ-009 Rom_rd  output  1  one-cycle read strobe; Rom_addr valid while high.
REQ-010 Active_clip  output  NUM_SRC  one-hot playing clip; all-zero when idle.
REQ-011 Busy  output  1  high in LOAD and PLAY.
REQ-012 Clip_done  output  1  one-cycle pulse when a clip plays to its end.

Function
REQ-013 Pending register SHALL set bit i on any cycle Req[i]=1 and Mute=0, except when clip i is currently active (request dropped).
REQ-014 Tick generator SHALL count 0..SAMPLE_DIV-1 free-running, tick=1 in the cycle count==SAMPLE_DIV-1, then wrap to 0.
REQ-015 States SHALL be IDLE, LOAD, PLAY, DONE.
REQ-016 IDLE: if pending!=0 and Mute=0, select lowest set index k, clear pending[k], go LOAD next edge.
REQ-017 LOAD (one cycle): addr<=CLIP_BASE[k], remaining<=CLIP_LEN[k]-1, Active_clip=one-hot(k), go PLAY.
REQ-018 PLAY on tick with no higher-priority pending: Rom_rd=1 for that cycle with current addr; addr+1; if remaining==0 go DONE else remaining-1.
REQ-019 PLAY on tick with pending bit j<k set: preempt -- no Rom_rd, select j, clear pending[j], go LOAD; no Clip_done for k; k not re-queued.
REQ-020 PLAY without tick SHALL hold all registers, Rom_rd=0.
REQ-021 DONE (one cycle): Clip_done=1, Active_clip=0, go IDLE.
REQ-022 Mute=1 in any state: next edge go IDLE, clear pending, Active_clip=0, no Clip_done; Rom_rd forced 0 combinationally.
REQ-023 Simultaneous Req for several clips in one cycle SHALL all latch; served strictly by priority.
REQ-024 Address arithmetic SHALL be ADDR_W-bit unsigned, wrap modulo 2^ADDR_W; CLIP_LEN >= 1 guaranteed by package.
REQ-025 A clip of length L SHALL produce exactly L Rom_rd strobes at consecutive ticks, addresses CLIP_BASE..CLIP_BASE+L-1.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force: state IDLE, pending 0, tick counter 0, addr 0, remaining 0, Rom_rd 0, Active_clip 0, Busy 0, Clip_done 0.
REQ-027 Reset mid-playback SHALL abandon the clip with no Clip_done; playback resumes only on new Req after Reset_n=1.

Structure
REQ-028 Shared package audio_pkg SHALL hold state enum, NUM_SRC, ADDR_W, SAMPLE_DIV defaults and CLIP_BASE/CLIP_LEN constant arrays.
REQ-029 Tick divider SHALL be sub-module sample_tick_gen (params SAMPLE_DIV; ports Clk, Reset_n, tick).
REQ-030 Priority select SHALL be combinational within audio_clip_scheduler; no other sub-modules.

Verification (bench: SAMPLE_DIV=4, CLIP_BASE[2]=100, CLIP_LEN[2]=3, CLIP_BASE[0]=10, CLIP_LEN[0]=2)
REQ-031 Single play: Req[2] pulse 1 cycle -> LOAD, Active_clip=0x04, Rom_rd at addrs 100,101,102 exactly 4 cycles apart, then Clip_done 1 cycle, Active_clip=0.
REQ-032 Preempt: Req[2], then Req[0] after first strobe -> next tick no strobe, Rom_addr 10,11 play, one Clip_done total, clip 2 not resumed.
REQ-033 Simultaneous: Req=0x05 same cycle -> clip 0 (10,11) plays, Clip_done, then clip 2 (100..102), Clip_done.
REQ-034 Drop/Mute: Req[2] while clip 2 playing -> exactly 3 strobes only; Mute=1 mid-clip -> Rom_rd 0 same cycle, IDLE next edge, pending 0, no Clip_done.
REQ-035 Reset: Reset_n low mid-PLAY -> all outputs 0 immediately without clock edge; after release no activity until new Req.

Source files
------------

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio clip scheduler: default parameters,
// scheduler state encoding and the clip table (start address and length of
// every sound effect in the sample ROM).
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int DEF_NUM_SRC    = 8;
  localparam int DEF_ADDR_W     = 18;
  localparam int DEF_SAMPLE_DIV = 1134;  // 50 MHz / ~44.1 kHz

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_DONE
  } sched_state_e;

  // Clip table, index 0 first. Every length is at least 1, so LEN-1 never
  // underflows when the playback counter is loaded. Clip 7 straddles the top
  // of the address space and wraps to address 0.
  localparam int unsigned CLIP_BASE [DEF_NUM_SRC] =
    '{10, 20, 100, 200, 300, 400, 500, 262142};
  localparam int unsigned CLIP_LEN  [DEF_NUM_SRC] =
    '{2, 4, 3, 5, 1, 6, 2, 4};

endpackage

// File: rtl/sample_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
// Free-running divider that produces a one-cycle tick every SAMPLE_DIV
// clocks (one tick per audio sample period).
//   Clk      : system clock
//   Reset_n  : asynchronous active-low reset (counter restarts at 0)
//   tick     : high in the cycle the counter equals SAMPLE_DIV-1
// ---------------------------------------------------------------------------
module sample_tick_gen
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int            CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state is always updated with non-blocking '<=' so
      // every flop samples pre-edge values regardless of statement order.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/audio_clip_scheduler.sv
// ---------------------------------------------------------------------------
// audio_clip_scheduler
// Latches sound-effect play requests and streams the selected clip out of
// the sample ROM at one address per sample tick. Lower request index means
// higher priority; a higher-priority request pre-empts the playing clip at
// the next tick, and the pre-empted clip is abandoned.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   Req          : per-clip play request (any high cycle latches it)
//   Mute         : aborts playback and discards all pending requests
//   Rom_addr     : sample ROM read address (valid while Rom_rd is high)
//   Rom_rd       : one-cycle ROM read strobe
//   Active_clip  : one-hot playing clip, zero when idle
//   Busy         : high while a clip is loading or playing
//   Clip_done    : one-cycle pulse when a clip plays to its end
// ---------------------------------------------------------------------------
module audio_clip_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_SRC-1:0] Req,
  input  logic               Mute,
  output logic [ADDR_W-1:0]  Rom_addr,
  output logic               Rom_rd,
  output logic [NUM_SRC-1:0] Active_clip,
  output logic               Busy,
  output logic               Clip_done
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  sched_state_e       state_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [SEL_W-1:0]   sel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  remaining_q;
  logic [NUM_SRC-1:0] active_q;
  logic               busy_q;
  logic               done_q;

  logic               tick;
  logic               any_pending;
  logic [SEL_W-1:0]   lowest_idx;
  logic               preempt;
  logic               take;
  logic               step;
  logic [NUM_SRC-1:0] take_mask;

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick    (tick)
  );

  // Priority select: lowest set pending index wins.
  always_comb begin
    // NOTE: give every always_comb output a default before any condition so
    // no path leaves it unassigned (which would infer a latch).
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest_idx = SEL_W'(i);
    end
  end

  assign any_pending = |pending_q;

  // A pending clip with a smaller index than the playing one takes over at
  // the tick instead of the next sample being read.
  assign preempt   = (state_q == ST_PLAY) && tick && any_pending && (lowest_idx < sel_q);
  assign take      = !Mute && any_pending && ((state_q == ST_IDLE) || preempt);
  assign step      = !Mute && (state_q == ST_PLAY) && tick && !preempt;
  assign take_mask = take ? (NUM_SRC'(1) << lowest_idx) : '0;

  // New requests for the clip already playing are dropped; a Mute cycle
  // discards everything.
  assign pending_d = Mute ? '0 : ((pending_q & ~take_mask) | (Req & ~active_q));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      active_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      done_q    <= 1'b0;
      if (Mute) begin
        state_q  <= ST_IDLE;
        active_q <= '0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (take) begin
              state_q  <= ST_LOAD;
              sel_q    <= lowest_idx;
              active_q <= take_mask;
              busy_q   <= 1'b1;
            end
          end
          ST_LOAD: begin
            addr_q      <= ADDR_W'(CLIP_BASE[sel_q]);
            remaining_q <= ADDR_W'(CLIP_LEN[sel_q] - 1);
            state_q     <= ST_PLAY;
          end
          ST_PLAY: begin
            if (take) begin
              state_q  <= ST_LOAD;
              sel_q    <= lowest_idx;
              active_q <= take_mask;
            end else if (step) begin
              addr_q <= addr_q + ADDR_W'(1);
              if (remaining_q == '0) begin
                state_q  <= ST_DONE;
                active_q <= '0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                remaining_q <= remaining_q - ADDR_W'(1);
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Rom_rd is decoded from the current cycle's tick so the strobe lines up
  // with the address register; Mute kills it in the same cycle.
  assign Rom_rd      = step;
  assign Rom_addr    = addr_q;
  assign Active_clip = active_q;
  assign Busy        = busy_q;
  assign Clip_done   = done_q;

endmodule

// File: tb/tb_audio_clip_scheduler.sv
// ---------------------------------------------------------------------------
// tb_audio_clip_scheduler
// Directed scenarios for the clip scheduler with SAMPLE_DIV=4. A behavioural
// model (clip number, samples already played, pending set) predicts every
// output on every falling edge; literal expectations pin the strobe address
// sequences, spacing and Clip_done counts of each scenario.
// ---------------------------------------------------------------------------
module tb_audio_clip_scheduler;

  localparam int NS  = 8;
  localparam int AW  = 18;
  localparam int DIV = 4;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_DONE = 3;

  localparam int unsigned BASE_TBL [NS] = '{10, 20, 100, 200, 300, 400, 500, 262142};
  localparam int unsigned LEN_TBL  [NS] = '{2, 4, 3, 5, 1, 6, 2, 4};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] req;
  logic          mute;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [NS-1:0] active_clip;
  logic          busy;
  logic          clip_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // model state
  int            m_mode, m_cur, m_played, m_cnt, m_low;
  logic [NS-1:0] m_pend;
  logic          m_tick, m_preempt;
  logic          e_rd, e_busy, e_done;
  logic [NS-1:0] e_act;

  // observation log
  int unsigned s_addr [$];
  int          s_cyc  [$];
  int          done_cnt = 0;
  int unsigned exp_a  [5];

  audio_clip_scheduler #(
    .NUM_SRC    (NS),
    .ADDR_W     (AW),
    .SAMPLE_DIV (DIV)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Req         (req),
    .Mute        (mute),
    .Rom_addr    (rom_addr),
    .Rom_rd      (rom_rd),
    .Active_clip (active_clip),
    .Busy        (busy),
    .Clip_done   (clip_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare process: evaluated on the falling edge, then the model is moved
  // on to the state the next rising edge will produce.
  initial begin
    m_mode = M_IDLE; m_pend = '0; m_cur = 0; m_played = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_rom_rd",      32'(rom_rd),      32'(0));
        check("rst_busy",        32'(busy),        32'(0));
        check("rst_active_clip", 32'(active_clip), 32'(0));
        check("rst_clip_done",   32'(clip_done),   32'(0));
        m_mode = M_IDLE; m_pend = '0; m_cur = 0; m_played = 0; m_cnt = 0;
      end else begin
        m_tick = (m_cnt == DIV - 1);
        m_low  = NS;
        for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) m_low = i;
        e_busy    = (m_mode == M_LOAD) || (m_mode == M_PLAY);
        e_act     = e_busy ? NS'(1 << m_cur) : '0;
        e_done    = (m_mode == M_DONE);
        m_preempt = (m_mode == M_PLAY) && m_tick && (m_low < m_cur);
        e_rd      = (m_mode == M_PLAY) && m_tick && !mute && !m_preempt;

        check("rom_rd",      32'(rom_rd),      32'(e_rd));
        check("busy",        32'(busy),        32'(e_busy));
        check("active_clip", 32'(active_clip), 32'(e_act));
        check("clip_done",   32'(clip_done),   32'(e_done));
        if (e_rd)
          check("rom_addr", 32'(rom_addr), (BASE_TBL[m_cur] + 32'(m_played)) % (32'd1 << AW));

        if (rom_rd) begin
          s_addr.push_back(32'(rom_addr));
          s_cyc.push_back(cyc);
        end
        if (clip_done) done_cnt++;

        if (mute) begin
          m_mode = M_IDLE;
          m_pend = '0;
        end else begin
          case (m_mode)
            M_IDLE: if (m_low < NS) begin
              m_pend[m_low] = 1'b0; m_cur = m_low; m_mode = M_LOAD;
            end
            M_LOAD: begin m_played = 0; m_mode = M_PLAY; end
            M_PLAY: if (m_tick) begin
              if (m_preempt) begin
                m_pend[m_low] = 1'b0; m_cur = m_low; m_mode = M_LOAD;
              end else begin
                m_played++;
                if (m_played == int'(LEN_TBL[m_cur])) m_mode = M_DONE;
              end
            end
            default: m_mode = M_IDLE;
          endcase
          m_pend = m_pend | (req & ~e_act);
        end
        m_cnt = (m_cnt + 1) % DIV;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_req(input logic [NS-1:0] v);
    req = v;
    step();
    req = '0;
  endtask

  task automatic clear_log();
    s_addr.delete();
    s_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k = 0;
    while (s_addr.size() < n && k < budget) begin
      step();
      k++;
    end
    if (s_addr.size() < n) check(tag, 32'(s_addr.size()), 32'(n));
  endtask

  // Stop in a cycle whose tick is high (m_cnt holds the current count here).
  task automatic wait_tick();
    int k = 0;
    while (m_cnt != DIV - 1 && k < 2 * DIV) begin
      step();
      k++;
    end
  endtask

  task automatic check_seq(input string tag, input int n);
    check($sformatf("%s_strobe_count", tag), 32'(s_addr.size()), 32'(n));
    for (int i = 0; i < n && i < s_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), s_addr[i], exp_a[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    mute  = 1'b0;
    run(3);
    check("reset_rom_addr", 32'(rom_addr),    32'(0));
    check("reset_busy",     32'(busy),        32'(0));
    check("reset_active",   32'(active_clip), 32'(0));
    rst_n = 1'b1;
    run(5);
    check("idle_no_strobes", 32'(s_addr.size()), 32'(0));

    // single play of clip 2
    clear_log();
    pulse_req(8'h04);
    step();
    check("single_load_active", 32'(active_clip), 32'h04);
    check("single_load_busy",   32'(busy),        32'(1));
    run(30);
    exp_a = '{100, 101, 102, 0, 0};
    check_seq("single", 3);
    if (s_cyc.size() >= 3) begin
      check("single_spacing01", 32'(s_cyc[1] - s_cyc[0]), 32'(4));
      check("single_spacing12", 32'(s_cyc[2] - s_cyc[1]), 32'(4));
    end
    check("single_done_cnt", 32'(done_cnt),    32'(1));
    check("single_end_idle", 32'(active_clip), 32'(0));

    // clip 0 pre-empts clip 2 after its first sample
    clear_log();
    pulse_req(8'h04);
    wait_strobes(1, 40, "preempt_first_strobe_timeout");
    pulse_req(8'h01);
    run(50);
    exp_a = '{100, 10, 11, 0, 0};
    check_seq("preempt", 3);
    check("preempt_done_cnt", 32'(done_cnt), 32'(1));

    // simultaneous requests served by priority
    clear_log();
    pulse_req(8'h05);
    run(60);
    exp_a = '{10, 11, 100, 101, 102};
    check_seq("simul", 5);
    check("simul_done_cnt", 32'(done_cnt), 32'(2));

    // re-request of the playing clip is dropped
    clear_log();
    pulse_req(8'h04);
    wait_strobes(1, 40, "drop_first_strobe_timeout");
    pulse_req(8'h04);
    run(40);
    exp_a = '{100, 101, 102, 0, 0};
    check_seq("drop", 3);
    check("drop_done_cnt", 32'(done_cnt), 32'(1));

    // Mute on a sample tick mid-clip with clip 3 pending
    clear_log();
    pulse_req(8'h04);
    wait_strobes(1, 40, "mute_first_strobe_timeout");
    pulse_req(8'h08);
    wait_tick();
    mute = 1'b1;
    #1;
    check("mute_rd_same_cycle", 32'(rom_rd), 32'(0));
    step();
    check("mute_active_next", 32'(active_clip), 32'(0));
    check("mute_busy_next",   32'(busy),        32'(0));
    req = 8'h01;
    step();
    req  = '0;
    mute = 1'b0;
    run(40);
    exp_a = '{100, 0, 0, 0, 0};
    check_seq("mute", 1);
    check("mute_done_cnt", 32'(done_cnt), 32'(0));

    // asynchronous reset in the middle of playback
    clear_log();
    pulse_req(8'h04);
    wait_strobes(1, 40, "reset_first_strobe_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rom_rd",   32'(rom_rd),      32'(0));
    check("async_rst_busy",     32'(busy),        32'(0));
    check("async_rst_active",   32'(active_clip), 32'(0));
    check("async_rst_done",     32'(clip_done),   32'(0));
    check("async_rst_rom_addr", 32'(rom_addr),    32'(0));
    run(3);
    rst_n = 1'b1;
    run(40);
    exp_a = '{100, 0, 0, 0, 0};
    check_seq("async_rst", 1);
    check("async_rst_done_cnt", 32'(done_cnt), 32'(0));

    // length-1 clip then a clip wrapping past the top address
    clear_log();
    pulse_req(8'h90);
    run(60);
    exp_a = '{300, 262142, 262143, 0, 1};
    check_seq("wrap", 5);
    check("wrap_done_cnt", 32'(done_cnt), 32'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
